// File: rtl/fft_pingpong_ram.sv
// Two-bank ping-pong sample buffer with EMPTY/FULL ownership tracking per bank.
// Optional `FFT_PP_BITREV_EN: bank-internal read address is the bit-reversed rd_addr.
module fft_pingpong_ram #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_done,
  output logic              wr_ready,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic              rd_done,
  output logic              rd_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              err
);

  localparam int unsigned DEPTH = 2 ** (ADDR_W + 1);

  typedef enum logic {
    BANK_EMPTY = 1'b0,
    BANK_FULL  = 1'b1
  } bank_st_t;

  bank_st_t          r_bank_st [2];
  bank_st_t          w_bank_st_nxt [2];
  logic              r_wr_bank;
  logic              r_rd_bank;
  logic [DATA_W-1:0] r_rd_data;
  logic              r_rd_valid;
  logic              r_err;

  logic [DATA_W-1:0] r_mem [DEPTH];

  logic              w_wr_ready;
  logic              w_rd_ready;
  logic              w_wr_acc;
  logic              w_wr_close;
  logic              w_rd_acc;
  logic              w_rd_close;
  logic              w_err_evt;
  logic [ADDR_W-1:0] w_rd_addr_phys;

  assign w_wr_ready = (r_bank_st[r_wr_bank] == BANK_EMPTY);
  assign w_rd_ready = (r_bank_st[r_rd_bank] == BANK_FULL);

  assign w_wr_acc   = wr_en   & w_wr_ready;
  assign w_wr_close = wr_done & w_wr_ready;
  assign w_rd_acc   = rd_en   & w_rd_ready;
  assign w_rd_close = rd_done & w_rd_ready;

  assign w_err_evt  = ((wr_en | wr_done) & ~w_wr_ready) |
                      ((rd_en | rd_done) & ~w_rd_ready);

`ifdef FFT_PP_BITREV_EN
  always_comb begin
    w_rd_addr_phys = '0;
    for (int unsigned i = 0; i < ADDR_W; i++) begin
      w_rd_addr_phys[i] = rd_addr[ADDR_W-1-i];
    end
  end
`else
  assign w_rd_addr_phys = rd_addr;
`endif

  // Both closes can fire together; when both are legal they target different banks.
  always_comb begin
    w_bank_st_nxt[0] = r_bank_st[0];
    w_bank_st_nxt[1] = r_bank_st[1];
    if (w_wr_close) begin
      w_bank_st_nxt[r_wr_bank] = BANK_FULL;
    end
    if (w_rd_close) begin
      w_bank_st_nxt[r_rd_bank] = BANK_EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_bank_st[0] <= BANK_EMPTY;
      r_bank_st[1] <= BANK_EMPTY;
      r_wr_bank    <= 1'b0;
      r_rd_bank    <= 1'b0;
      r_rd_valid   <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_bank_st[0] <= w_bank_st_nxt[0];
      r_bank_st[1] <= w_bank_st_nxt[1];
      if (w_wr_close) begin
        r_wr_bank <= ~r_wr_bank;
      end
      if (w_rd_close) begin
        r_rd_bank <= ~r_rd_bank;
      end
      r_rd_valid <= w_rd_acc;
      r_err      <= r_err | w_err_evt;
    end
  end

  // Storage stays reset-free so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (w_wr_acc) begin
      r_mem[{r_wr_bank, wr_addr}] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd_data <= '0;
    end else if (w_rd_acc) begin
      r_rd_data <= r_mem[{r_rd_bank, w_rd_addr_phys}];
    end
  end

  assign wr_ready = w_wr_ready;
  assign rd_ready = w_rd_ready;
  assign rd_data  = r_rd_data;
  assign rd_valid = r_rd_valid;
  assign err      = r_err;

endmodule
